// File: rtl/pwm_dac_multi.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_dac_multi
//  Description : Multi-channel PWM DAC with one shared period counter,
//                double-buffered duty/period/mode and edge/center alignment.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_dac_multi #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 10,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [WIDTH-1:0]  period,
  input  logic              center_mode,
  input  logic              duty_wr_en,
  input  logic [CH_W-1:0]   duty_wr_ch,
  input  logic [WIDTH-1:0]  duty_wr_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              zero,
  output logic [NUM_CH-1:0] update_pending
);

  localparam logic [0:0]       c_DIR_UP   = 1'b0;
  localparam logic [0:0]       c_DIR_DOWN = 1'b1;
  localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);

  logic [WIDTH-1:0]  r_cnt;
  logic [0:0]        r_dir;
  logic [WIDTH-1:0]  w_cnt_next;
  logic [0:0]        w_dir_next;

  logic [WIDTH-1:0]  r_sh_period;
  logic              r_sh_mode;
  logic [WIDTH-1:0]  r_act_period;
  logic              r_act_mode;
  logic [WIDTH-1:0]  r_sh_duty  [NUM_CH];
  logic [WIDTH-1:0]  r_act_duty [NUM_CH];
  logic [NUM_CH-1:0] r_pending;

  logic              w_boundary;
  logic [WIDTH-1:0]  w_eff_period;
  logic              w_eff_mode;
  logic [WIDTH-1:0]  w_eff_duty [NUM_CH];
  logic              w_wr_valid;
  logic [NUM_CH-1:0] w_wr_hit;
  logic [NUM_CH-1:0] w_pending_next;
  logic [NUM_CH-1:0] w_pwm_next;

  assign w_boundary     = enable && (r_cnt == '0) && (r_dir == c_DIR_UP);
  // At a boundary the freshly promoted values already govern this cycle.
  assign w_eff_period   = w_boundary ? r_sh_period : r_act_period;
  assign w_eff_mode     = w_boundary ? r_sh_mode   : r_act_mode;
  assign update_pending = r_pending;

  generate
    if (NUM_CH == (1 << CH_W)) begin : g_full_ch
      assign w_wr_valid = duty_wr_en;
    end else begin : g_partial_ch
      assign w_wr_valid = duty_wr_en && (32'(duty_wr_ch) < 32'(NUM_CH));
    end
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_hit
      assign w_wr_hit[gi]       = w_wr_valid && (duty_wr_ch == CH_W'(gi));
      assign w_pending_next[gi] = w_boundary ? 1'b0 : (r_pending[gi] | w_wr_hit[gi]);
    end
  endgenerate

  // A write landing on a boundary beats the older shadow value.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_eff_duty[i] = r_act_duty[i];
      if (w_boundary) begin
        if (w_wr_hit[i]) begin
          w_eff_duty[i] = duty_wr_data;
        end else if (r_pending[i]) begin
          w_eff_duty[i] = r_sh_duty[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_dir <= c_DIR_UP;
    end else if (enable) begin
      r_cnt <= w_cnt_next;
      r_dir <= w_dir_next;
    end
  end

  always_comb begin
    w_cnt_next = r_cnt;
    w_dir_next = r_dir;
    if (w_eff_period == '0) begin
      w_cnt_next = '0;
      w_dir_next = c_DIR_UP;
    end else if ((r_dir == c_DIR_DOWN) || (w_eff_mode && (r_cnt >= w_eff_period))) begin
      w_cnt_next = r_cnt - c_ONE;
      w_dir_next = (r_cnt == c_ONE) ? c_DIR_UP : c_DIR_DOWN;
    end else if (r_cnt >= w_eff_period) begin
      w_cnt_next = '0;
      w_dir_next = c_DIR_UP;
    end else begin
      w_cnt_next = r_cnt + c_ONE;
      w_dir_next = c_DIR_UP;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_pwm_next[i] = (r_cnt < w_eff_duty[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh_period  <= '0;
      r_sh_mode    <= 1'b0;
      r_act_period <= '0;
      r_act_mode   <= 1'b0;
      r_pending    <= '0;
      pwm_out      <= '0;
      zero         <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_sh_duty[i]  <= '0;
        r_act_duty[i] <= '0;
      end
    end else begin
      r_sh_period <= period;
      r_sh_mode   <= center_mode;
      r_pending   <= w_pending_next;
      if (enable) begin
        pwm_out <= w_pwm_next;
        zero    <= w_boundary;
      end
      if (w_boundary) begin
        r_act_period <= r_sh_period;
        r_act_mode   <= r_sh_mode;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr_hit[i]) begin
          r_sh_duty[i] <= duty_wr_data;
        end
        if (w_boundary) begin
          r_act_duty[i] <= w_eff_duty[i];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_dac_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_dac_multi
//  Description : Self-checking bench for pwm_dac_multi (vectors, scenarios,
//                randomized traffic against a phase-based reference model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_dac_multi;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 10;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic [WIDTH-1:0]  period = '0;
  logic              center_mode = 1'b0;
  logic              duty_wr_en = 1'b0;
  logic [CH_W-1:0]   duty_wr_ch = '0;
  logic [WIDTH-1:0]  duty_wr_data = '0;
  logic [NUM_CH-1:0] pwm_out;
  logic              zero;
  logic [NUM_CH-1:0] update_pending;

  pwm_dac_multi #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .CH_W(CH_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .center_mode(center_mode), .duty_wr_en(duty_wr_en), .duty_wr_ch(duty_wr_ch),
    .duty_wr_data(duty_wr_data), .pwm_out(pwm_out), .zero(zero),
    .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: tracks the position within the current period, and
  // derives the count value from it with plain arithmetic.
  int unsigned m_phase, m_per, m_sh_per;
  bit          m_mode, m_sh_mode;
  int unsigned m_duty [NUM_CH];
  int unsigned m_sh_duty [NUM_CH];
  bit [NUM_CH-1:0] m_pend, m_pwm;
  bit          m_zero;

  function automatic void model_reset();
    m_phase = 0; m_per = 0; m_sh_per = 0; m_mode = 0; m_sh_mode = 0;
    m_pend = '0; m_pwm = '0; m_zero = 0;
    for (int i = 0; i < NUM_CH; i++) begin m_duty[i] = 0; m_sh_duty[i] = 0; end
  endfunction

  function automatic void model_step();
    bit b;
    int unsigned cnt, len;
    b = enable && (m_phase == 0);
    if (b) begin
      m_per  = m_sh_per;
      m_mode = m_sh_mode;
      for (int i = 0; i < NUM_CH; i++) if (m_pend[i]) m_duty[i] = m_sh_duty[i];
      m_pend = '0;
    end
    if (duty_wr_en && (int'(duty_wr_ch) < NUM_CH)) begin
      m_sh_duty[duty_wr_ch] = duty_wr_data;
      if (b) m_duty[duty_wr_ch] = duty_wr_data;
      else   m_pend[duty_wr_ch] = 1'b1;
    end
    if (enable) begin
      cnt = (m_phase <= m_per) ? m_phase : 2 * m_per - m_phase;
      for (int i = 0; i < NUM_CH; i++) m_pwm[i] = (cnt < m_duty[i]);
      m_zero = b;
      len = (m_per == 0) ? 1 : (m_mode ? 2 * m_per : m_per + 1);
      m_phase = (m_phase + 1) % len;
    end
    m_sh_per  = period;
    m_sh_mode = center_mode;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("model_pwm",  32'(pwm_out), 32'(m_pwm));
    check("model_zero", 32'(zero), 32'(m_zero));
    check("model_pend", 32'(update_pending), 32'(m_pend));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_pwm",  32'(pwm_out), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_pend", 32'(update_pending), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic wr(input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] d);
    duty_wr_en = 1'b1; duty_wr_ch = ch; duty_wr_data = d;
  endtask

  typedef struct packed {
    logic              en;
    logic [WIDTH-1:0]  per;
    logic              wr;
    logic [CH_W-1:0]   ch;
    logic [WIDTH-1:0]  data;
    logic [NUM_CH-1:0] pwm;
    logic              z;
    logic [NUM_CH-1:0] pend;
  } vec_t;

  vec_t tbl [13];
  int   h;

  initial begin
    // Period 7 edge mode; ch3 written on the first boundary, ch0 mid-period.
    tbl[0]  = '{1'b0, 10'd7, 1'b0, 2'd0, 10'd0, 4'b0000, 1'b0, 4'b0000};
    tbl[1]  = '{1'b1, 10'd7, 1'b1, 2'd3, 10'd6, 4'b1000, 1'b1, 4'b0000};
    tbl[2]  = '{1'b1, 10'd7, 1'b0, 2'd0, 10'd0, 4'b1000, 1'b0, 4'b0000};
    tbl[3]  = '{1'b1, 10'd7, 1'b0, 2'd0, 10'd0, 4'b1000, 1'b0, 4'b0000};
    tbl[4]  = '{1'b1, 10'd7, 1'b1, 2'd0, 10'd2, 4'b1000, 1'b0, 4'b0001};
    tbl[5]  = '{1'b1, 10'd7, 1'b0, 2'd0, 10'd0, 4'b1000, 1'b0, 4'b0001};
    tbl[6]  = '{1'b1, 10'd7, 1'b0, 2'd0, 10'd0, 4'b1000, 1'b0, 4'b0001};
    tbl[7]  = '{1'b1, 10'd7, 1'b0, 2'd0, 10'd0, 4'b0000, 1'b0, 4'b0001};
    tbl[8]  = '{1'b0, 10'd7, 1'b0, 2'd0, 10'd0, 4'b0000, 1'b0, 4'b0001};
    tbl[9]  = '{1'b1, 10'd7, 1'b0, 2'd0, 10'd0, 4'b0000, 1'b0, 4'b0001};
    tbl[10] = '{1'b1, 10'd7, 1'b0, 2'd0, 10'd0, 4'b1001, 1'b1, 4'b0000};
    tbl[11] = '{1'b1, 10'd7, 1'b0, 2'd0, 10'd0, 4'b1001, 1'b0, 4'b0000};
    tbl[12] = '{1'b1, 10'd7, 1'b0, 2'd0, 10'd0, 4'b1000, 1'b0, 4'b0000};

    model_reset();
    reset = 1'b1;
    #12;
    do_reset();

    for (int v = 0; v < 13; v++) begin
      enable = tbl[v].en; period = tbl[v].per; center_mode = 1'b0;
      duty_wr_en = tbl[v].wr; duty_wr_ch = tbl[v].ch; duty_wr_data = tbl[v].data;
      tick();
      check($sformatf("vec%0d_pwm", v),  32'(pwm_out), 32'(tbl[v].pwm));
      check($sformatf("vec%0d_zero", v), 32'(zero), 32'(tbl[v].z));
      check($sformatf("vec%0d_pend", v), 32'(update_pending), 32'(tbl[v].pend));
    end
    duty_wr_en = 1'b0;

    // Edge mode, period 9, ch0 duty 3.
    do_reset();
    enable = 1'b0; period = 10'd9; center_mode = 1'b0;
    wr(2'd0, 10'd3);
    tick();
    duty_wr_en = 1'b0; enable = 1'b1;
    begin
      int zc, bad;
      h = 0; zc = 0; bad = 0;
      for (int k = 0; k < 20; k++) begin
        tick();
        h += int'(pwm_out[0]);
        if (zero) begin zc++; if (!pwm_out[0]) bad++; end
      end
      check("t1_highs", 32'(h), 32'd6);
      check("t1_zeros", 32'(zc), 32'd2);
      check("t1_zero_with_high", 32'(bad), 32'd0);
    end

    // Mid-period duty change on ch1.
    wr(2'd1, 10'd5);
    tick();
    duty_wr_en = 1'b0;
    h = int'(pwm_out[1]);
    for (int k = 0; k < 3; k++) begin tick(); h += int'(pwm_out[1]); end
    wr(2'd1, 10'd8);
    tick();
    duty_wr_en = 1'b0;
    h += int'(pwm_out[1]);
    check("t2_pend_set", 32'(update_pending[1]), 32'd1);
    for (int k = 0; k < 5; k++) begin tick(); h += int'(pwm_out[1]); end
    check("t2_pend_hold", 32'(update_pending[1]), 32'd1);
    check("t2_old_highs", 32'(h), 32'd5);
    h = 0;
    for (int k = 0; k < 10; k++) begin tick(); h += int'(pwm_out[1]); end
    check("t2_new_highs", 32'(h), 32'd8);
    check("t2_pend_clr", 32'(update_pending[1]), 32'd0);

    // Center mode, period 4, ch2 duty 2.
    period = 10'd4; center_mode = 1'b1;
    wr(2'd2, 10'd2);
    tick();
    duty_wr_en = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    for (int k = 0; k < 16; k++) begin
      int ph;
      tick();
      ph = k % 8;
      check("t3_pwm2", 32'(pwm_out[2]), (ph == 0 || ph == 1 || ph == 7) ? 32'd1 : 32'd0);
      check("t3_zero", 32'(zero), (ph == 0) ? 32'd1 : 32'd0);
    end

    // Boundary duties at period 7.
    period = 10'd7; center_mode = 1'b0;
    wr(2'd0, 10'd0);    tick();
    wr(2'd1, 10'd8);    tick();
    wr(2'd2, 10'd1023); tick();
    duty_wr_en = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    for (int k = 0; k < 16; k++) begin
      tick();
      check("t4_bits", 32'(pwm_out[2:0]), 32'b110);
    end

    // Enable freeze, then asynchronous reset mid-period.
    for (int k = 0; k < 3; k++) tick();
    enable = 1'b0;
    wr(2'd3, 10'd5);
    tick();
    duty_wr_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t6_hold_bits", 32'(pwm_out[2:0]), 32'b110);
      check("t6_hold_zero", 32'(zero), 32'd0);
      check("t6_hold_pend", 32'(update_pending[3]), 32'd1);
    end
    enable = 1'b1;
    tick(); tick();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      tick();
      check("t6_post_rst_pwm", 32'(pwm_out), 32'd0);
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      enable      = ($urandom_range(0, 9) != 0);
      period      = ($urandom_range(0, 15) == 0) ? WIDTH'($urandom_range(0, 40))
                                                 : WIDTH'($urandom_range(0, 12));
      center_mode = ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0;
      duty_wr_en  = ($urandom_range(0, 4) == 0);
      duty_wr_ch  = CH_W'($urandom_range(0, NUM_CH - 1));
      duty_wr_data = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom)
                                                 : WIDTH'($urandom_range(0, 14));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_dac_multi.md
Name: pwm_dac_multi

Overview:
- Multi-channel PWM DAC that generalises the single-channel PWM DAC in three ways: channel count, counter width, and an alignment mode.
- One shared period counter drives NUM_CH independent duty comparators.
- Duty, period and mode writes are double-buffered (shadow, then active) and take effect only at a period boundary, so outputs never glitch.
- Sits between the register/control logic and the analog RC-filter output pins.

Parameters:
- NUM_CH, 4, number of PWM channels (1..16).
- WIDTH, 10, width of the counter, period and duty values.
- CH_W, $clog2(NUM_CH) (min 1), width of the channel-select field.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  counter advance enable; when low, all state holds.
- period  in  WIDTH  maximum count value; written to shadow every cycle.
- center_mode  in  1  0 = edge-aligned, 1 = center-aligned; written to shadow every cycle.
- duty_wr_en  in  1  duty write strobe.
- duty_wr_ch  in  CH_W  target channel for the duty write.
- duty_wr_data  in  WIDTH  duty value for the duty write.
- pwm_out  out  NUM_CH  registered PWM outputs.
- zero  out  1  registered one-cycle pulse marking each period boundary.
- update_pending  out  NUM_CH  bit i set while channel i holds a shadow duty not yet applied.

Behaviour:
- Reset (asynchronous, any time, including mid-period):
  - counter = 0, direction = up.
  - Shadow and active duty/period/mode registers = 0.
  - pwm_out = 0, zero = 0, update_pending = 0.
  - First boundary occurs on the first enabled cycle after reset deassertion.
- Boundary (B): a cycle with enable=1 and counter==0 while counting up. At B:
  - active_period <= shadow period; active_mode <= shadow mode.
  - For every channel with update_pending set, active_duty <= shadow duty and its pending bit clears.
- Duty write: if duty_wr_en=1, shadow_duty[duty_wr_ch] <= duty_wr_data and update_pending[ch] <= 1.
  - Write in the same cycle as B: the written data goes directly into active_duty and pending stays 0 (write wins).
  - Out-of-range duty_wr_ch (>= NUM_CH): write ignored.
- Counter, edge mode:
  - Counts 0..active_period, then wraps to 0.
  - Period length = active_period+1 cycles.
- Counter, center mode:
  - Counts up 0..active_period, then down active_period-1..1, then 0 (which is B).
  - Period length = 2*active_period cycles.
- Degenerate period: active_period==0 in either mode means the counter stays 0 and every enabled cycle is a boundary.
- Mode change takes effect only at B; direction is always reset to up at B.
- Output registers, updated when enable=1:
  - pwm_out[i] <= (counter < active_duty[i]), using the active values of the current cycle.
  - zero <= B.
  - Outputs therefore lag the counter by exactly 1 cycle.
- enable=0: counter, direction, outputs, active registers and zero all hold. Shadow writes and pending flags still update.
- Boundary duty values:
  - duty = 0 gives constant 0.
  - duty > active_period (edge) or duty >= active_period+1 gives constant 1 (100%).
- Duty cycle:
  - Edge mode: duty/(period+1).
  - Center mode: high for counts < duty on both the up and down ramp, so the pulse is symmetric about count 0.
  - Center-mode high time = 2*duty-1 cycles for 1 <= duty <= period.
- Arithmetic: all compares are unsigned at WIDTH bits; there is no overflow because the counter never exceeds active_period.

Test Plan:
1. Reset, then period=9, edge mode, write ch0 duty=3, enable=1. Required: after the first B, pwm_out[0] high 3 of every 10 cycles. zero pulses every 10 cycles, coincident with the first high cycle of pwm_out[0].
2. Mid-period duty change: ch1 duty=5, period=9; write duty=8 at count 4. Required: current period keeps 5 high cycles. update_pending[1]=1 until the next B, then 8 high cycles per period.
3. Center mode, period=4, ch2 duty=2. Required: counter sequence 0,1,2,3,4,3,2,1 repeats (8 cycles). pwm_out[2] high for counts 0,1 and 1, i.e. 3 cycles per period, symmetric about zero.
4. Boundary duties, period=7: duty=0 gives pwm_out constant 0; duty=8 and duty=1023 give constant 1.
5. Write in the same cycle as B: ch3 duty=6. Required: applied in that period immediately, and update_pending[3] never asserts.
6. Assert enable=0 for 5 cycles mid-period, then assert reset mid-period. Required: during enable=0, counter and pwm_out freeze. On reset, pwm_out=0, zero=0 and pending=0 immediately. After reset deassertion, outputs stay 0 until new duty writes land.
